// File: rtl/reg2mem_sequencer.sv
// reg2mem_sequencer: turns WRITE/READ/COPY/SWAP requests into timed
// reg2mem opcode sequences and returns the sampled result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The request side is ready only in IDLE. The response side holds
// rsp_valid and a stable rsp_data until rsp_ready is seen.
module reg2mem_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [3:0]  R0          = 4'd14,
  parameter logic [3:0]  R1          = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_cmd,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [3:0] req_data,
  output logic [9:0] opcode,
  input  logic [3:0] res,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [9:0] IDLE_OP   = 10'b11_0000_0000;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  localparam logic [1:0] CMD_WRITE = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_COPY  = 2'b10;
  localparam logic [1:0] CMD_SWAP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_step;
  logic [3:0] r_hold;
  logic [1:0] r_cmd;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [3:0] r_data;
  logic [9:0] r_opcode;
  logic       r_req_ready;
  logic       r_rsp_valid;
  logic       r_busy;
  logic [3:0] r_rsp_data;

  logic [2:0] w_step_next;
  logic [2:0] w_last_step;
  logic [3:0] w_rsp_value;

  // Step table: opcode for a given command and step index.
  function automatic logic [9:0] step_op(input logic [1:0] cmd,
                                         input logic [2:0] step,
                                         input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [3:0] d);
    logic [9:0] op;
    op = IDLE_OP;
    case (cmd)
      CMD_WRITE: op = {2'b00, d, b};
      CMD_READ:  op = {2'b11, 4'h0, b};
      CMD_COPY: begin
        case (step)
          3'd0:    op = {2'b10, R0, a};
          3'd1:    op = {2'b01, R0, b};
          default: op = {2'b11, 4'h0, b};
        endcase
      end
      default: begin
        case (step)
          3'd0:    op = {2'b10, R0, a};
          3'd1:    op = {2'b10, R1, b};
          3'd2:    op = {2'b01, R0, b};
          default: op = {2'b01, R1, a};
        endcase
      end
    endcase
    return op;
  endfunction

  // Index of the final step and the response value for the latched command.
  always_comb begin
    w_step_next = r_step + 3'd1;
    w_last_step = 3'd0;
    w_rsp_value = 4'd0;
    case (r_cmd)
      CMD_WRITE: begin
        w_last_step = 3'd0;
        w_rsp_value = r_data;
      end
      CMD_READ: begin
        w_last_step = 3'd0;
        w_rsp_value = res;
      end
      CMD_COPY: begin
        w_last_step = 3'd2;
        w_rsp_value = res;
      end
      default: begin
        w_last_step = 3'd3;
        w_rsp_value = 4'd0;
      end
    endcase
  end

  // Sequencer FSM: accept, issue each step for HOLD_CYCLES cycles, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_step      <= 3'd0;
      r_hold      <= 4'd0;
      r_cmd       <= 2'd0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_data      <= 4'd0;
      r_opcode    <= IDLE_OP;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_data  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_cmd       <= req_cmd;
            r_a         <= req_a;
            r_b         <= req_b;
            r_data      <= req_data;
            r_step      <= 3'd0;
            r_hold      <= 4'd0;
            r_opcode    <= step_op(req_cmd, 3'd0, req_a, req_b, req_data);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_hold == HOLD_LAST) begin
            r_hold <= 4'd0;
            if (r_step == w_last_step) begin
              // res reflects the read opcode that has just been held.
              r_rsp_data  <= w_rsp_value;
              r_rsp_valid <= 1'b1;
              r_opcode    <= IDLE_OP;
              r_state     <= S_RESP;
            end else begin
              r_step   <= w_step_next;
              r_opcode <= step_op(r_cmd, w_step_next, r_a, r_b, r_data);
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_opcode    <= IDLE_OP;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign opcode    = r_opcode;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg2mem_sequencer.sv
// Bench for reg2mem_sequencer: a reg2mem stand-in, a memory-level model with
// a per-cycle opcode queue, one negedge compare process, directed literal
// cases and a randomized phase. A second instance runs with HOLD_CYCLES=1.
module tb_reg2mem_sequencer;

  localparam int         HOLD    = 2;
  localparam logic [9:0] IDLE_OP = 10'b11_0000_0000;
  localparam logic [3:0] SR0     = 4'd14;
  localparam logic [3:0] SR1     = 4'd15;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (HOLD_CYCLES = 2) ----------------
  logic       rst;
  logic       req_valid, req_ready;
  logic [1:0] req_cmd;
  logic [3:0] req_a, req_b, req_data;
  logic [9:0] opcode;
  logic [3:0] res;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;
  logic [1:0] dbg_state;

  reg2mem_sequencer #(.HOLD_CYCLES(HOLD), .R0(SR0), .R1(SR1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_a(req_a), .req_b(req_b), .req_data(req_data),
    .opcode(opcode), .res(res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (HOLD_CYCLES = 1) ----------------
  logic       req_valid1, req_ready1;
  logic [1:0] req_cmd1;
  logic [3:0] req_a1, req_b1, req_data1;
  logic [9:0] opcode1;
  logic [3:0] res1;
  logic       rsp_valid1, rsp_ready1;
  logic [3:0] rsp_data1;
  logic       busy1;
  logic [1:0] dbg_state1;

  reg2mem_sequencer #(.HOLD_CYCLES(1), .R0(SR0), .R1(SR1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_cmd(req_cmd1),
    .req_a(req_a1), .req_b(req_b1), .req_data(req_data1),
    .opcode(opcode1), .res(res1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .busy(busy1), .dbg_state(dbg_state1)
  );

  // ---------------- reg2mem stand-ins ----------------
  logic [3:0] s_mem [16] = '{default: 4'd0};
  logic [3:0] s_reg [16] = '{default: 4'd0};
  logic [3:0] s_mem1[16] = '{default: 4'd0};
  logic [3:0] s_reg1[16] = '{default: 4'd0};

  always @(posedge clk) begin
    case (opcode[9:8])
      2'b00:   s_mem[opcode[3:0]] <= opcode[7:4];
      2'b10:   s_reg[opcode[7:4]] <= s_mem[opcode[3:0]];
      2'b01:   s_mem[opcode[3:0]] <= s_reg[opcode[7:4]];
      default: ;
    endcase
    case (opcode1[9:8])
      2'b00:   s_mem1[opcode1[3:0]] <= opcode1[7:4];
      2'b10:   s_reg1[opcode1[7:4]] <= s_mem1[opcode1[3:0]];
      2'b01:   s_mem1[opcode1[3:0]] <= s_reg1[opcode1[7:4]];
      default: ;
    endcase
  end

  assign res  = (opcode[9:8]  == 2'b11) ? s_mem[opcode[3:0]]   : 4'd0;
  assign res1 = (opcode1[9:8] == 2'b11) ? s_mem1[opcode1[3:0]] : 4'd0;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the opcode expected in each upcoming cycle of a command;
  // m_mem is the memory contents as seen at the level of whole commands.
  logic [9:0] exp_q[$];
  logic [3:0] m_mem[16]      = '{default: 4'd0};
  logic [3:0] m_mem_save[16] = '{default: 4'd0};
  bit         m_resp = 1'b0;
  logic [3:0] m_rsp  = 4'd0;
  logic [3:0] ma, mb, md, mt;

  task automatic push_op(input logic [9:0] op);
    for (int i = 0; i < HOLD; i++) exp_q.push_back(op);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      // Aborted commands here are only interrupted before any store lands.
      if (exp_q.size() != 0) m_mem = m_mem_save;
      exp_q.delete();
      m_resp = 1'b0;
    end else if (m_resp) begin
      if (rsp_ready) m_resp = 1'b0;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_resp = 1'b1;
    end else if (req_valid) begin
      m_mem_save = m_mem;
      ma = req_a; mb = req_b; md = req_data;
      case (req_cmd)
        2'b00: begin
          push_op({2'b00, md, mb});
          m_mem[mb] = md;
          m_rsp = md;
        end
        2'b01: begin
          push_op({2'b11, 4'h0, mb});
          m_rsp = m_mem[mb];
        end
        2'b10: begin
          push_op({2'b10, SR0, ma});
          push_op({2'b01, SR0, mb});
          push_op({2'b11, 4'h0, mb});
          m_rsp = m_mem[ma];
          m_mem[mb] = m_mem[ma];
        end
        default: begin
          push_op({2'b10, SR0, ma});
          push_op({2'b10, SR1, mb});
          push_op({2'b01, SR0, mb});
          push_op({2'b01, SR1, ma});
          mt = m_mem[ma];
          m_mem[ma] = m_mem[mb];
          m_mem[mb] = mt;
          m_rsp = 4'd0;
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("opcode",    opcode,    (exp_q.size() != 0) ? exp_q[0] : IDLE_OP);
    chk("rsp_valid", rsp_valid, m_resp);
    chk("req_ready", req_ready, (exp_q.size() == 0) && !m_resp);
    chk("busy",      busy,      (exp_q.size() != 0) || m_resp);
    if (m_resp) chk("rsp_data", rsp_data, m_rsp);
  end

  // ---------------- driver tasks ----------------
  logic [9:0] seen_ops[$];

  function automatic logic [9:0] seen(input int i);
    return (i < seen_ops.size()) ? seen_ops[i] : 10'bx;
  endfunction

  // Issue one command on the HOLD=2 instance; returns latency from accept to
  // rsp_valid, the first response value and the value at the end of a stall.
  task automatic send(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input int stall, input bit noise,
                      output int lat, output logic [3:0] rd, output logic [3:0] rd_end);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", req_ready, 1);
    req_valid = 1'b1; req_cmd = c; req_a = a; req_b = b; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    seen_ops.delete();
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (seen_ops.size() == 0 || seen_ops[seen_ops.size()-1] != opcode)
        seen_ops.push_back(opcode);
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_cmd   = 2'($urandom_range(0, 3));
        req_a     = 4'($urandom_range(0, 15));
        req_b     = 4'($urandom_range(0, 15));
        req_data  = 4'($urandom_range(0, 15));
        rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    rd = rsp_data;
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      req_valid = (i == 1);
      @(negedge clk);
    end
    rd_end = rsp_data;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Issue one command on the HOLD=1 instance (rsp_ready1 is tied high).
  task automatic send1(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, output int lat, output logic [3:0] rd);
    req_valid1 = 1'b1; req_cmd1 = c; req_a1 = a; req_b1 = b; req_data1 = d;
    @(negedge clk);
    req_valid1 = 1'b0;
    seen_ops.delete();
    lat = 0;
    while (!rsp_valid1 && lat < 20) begin
      seen_ops.push_back(opcode1);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid1) chk("rsp1_timeout", rsp_valid1, 1);
    rd = rsp_data1;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int         lat;
    logic [3:0] rd, rd_end;

    rst = 1'b1;
    req_valid = 1'b0; req_cmd = 2'd0; req_a = 4'd0; req_b = 4'd0; req_data = 4'd0;
    rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_cmd1 = 2'd0; req_a1 = 4'd0; req_b1 = 4'd0; req_data1 = 4'd0;
    rsp_ready1 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_opcode",    opcode,    10'b1100000000);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data,  0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the 3rd ISSUE cycle of SWAP a=1 b=2
    req_valid = 1'b1; req_cmd = 2'b11; req_a = 4'd1; req_b = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("swap_abort_step0", opcode, 10'b1011100001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_opcode",    opcode,    10'b1100000000);
    chk("abort_busy",      busy,      0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // WRITE mem[5]=10 then READ 5
    send(2'b00, 4'd0, 4'd5, 4'd10, 0, 1'b0, lat, rd, rd_end);
    chk("write_op",  seen(0), 10'b0010100101);
    chk("write_lat", lat, 2);
    chk("write_rsp", rd, 10);
    send(2'b01, 4'd0, 4'd5, 4'd0, 0, 1'b0, lat, rd, rd_end);
    chk("read_op",  seen(0), 10'b1100000101);
    chk("read_lat", lat, 2);
    chk("read_rsp", rd, 10);

    // COPY 5 -> 11
    send(2'b10, 4'd5, 4'd11, 4'd0, 0, 1'b0, lat, rd, rd_end);
    chk("copy_nops", seen_ops.size(), 3);
    chk("copy_op0",  seen(0), 10'b1011100101);
    chk("copy_op1",  seen(1), 10'b0111101011);
    chk("copy_op2",  seen(2), 10'b1100001011);
    chk("copy_lat",  lat, 6);
    chk("copy_rsp",  rd, 10);

    // SWAP mem[1]=3, mem[2]=9
    send(2'b00, 4'd0, 4'd1, 4'd3, 0, 1'b0, lat, rd, rd_end);
    send(2'b00, 4'd0, 4'd2, 4'd9, 0, 1'b0, lat, rd, rd_end);
    send(2'b11, 4'd1, 4'd2, 4'd0, 0, 1'b0, lat, rd, rd_end);
    chk("swap_nops", seen_ops.size(), 4);
    chk("swap_lat",  lat, 8);
    chk("swap_rsp",  rd, 0);
    send(2'b01, 4'd0, 4'd1, 4'd0, 0, 1'b0, lat, rd, rd_end);
    chk("swap_read1", rd, 9);
    send(2'b01, 4'd0, 4'd2, 4'd0, 0, 1'b0, lat, rd, rd_end);
    chk("swap_read2", rd, 3);

    // Backpressure: 5-cycle stall with a stray request pulse
    send(2'b01, 4'd0, 4'd11, 4'd0, 5, 1'b0, lat, rd, rd_end);
    chk("bp_rsp",    rd, 10);
    chk("bp_stable", rd_end, 10);

    // HOLD_CYCLES = 1 instance
    send1(2'b00, 4'd0, 4'd5, 4'd7, lat, rd);
    chk("h1_write_lat", lat, 1);
    chk("h1_write_rsp", rd, 7);
    send1(2'b10, 4'd5, 4'd11, 4'd0, lat, rd);
    chk("h1_copy_nops", seen_ops.size(), 3);
    chk("h1_copy_op0",  seen(0), 10'b1011100101);
    chk("h1_copy_op1",  seen(1), 10'b0111101011);
    chk("h1_copy_op2",  seen(2), 10'b1100001011);
    chk("h1_copy_lat",  lat, 3);
    chk("h1_copy_rsp",  rd, 7);

    // Randomized commands with noise on don't-care inputs and random stalls
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1, lat, rd, rd_end);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg2mem_sequencer.md
# reg2mem_sequencer

Command sequencer that drives the `reg2mem` register/memory block. It accepts high-level memory commands over a valid/ready request port and expands each command into a timed sequence of 10-bit `reg2mem` opcodes, holding each opcode for a fixed number of cycles. It samples `reg2mem`'s `res` output and returns it on a valid/ready response port. It sits between a controller or test harness and `reg2mem`, and replaces hand-sequenced opcode stimulus.

## Interface
Parameters:
- `HOLD_CYCLES`, default 2: cycles each opcode is held on `opcode`; legal range 1..15.
- `R0`, default 4'd14: scratch register index, used by COPY and SWAP.
- `R1`, default 4'd15: second scratch register index, used by SWAP.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_cmd`  in  2  00 WRITE, 01 READ, 10 COPY, 11 SWAP.
- `req_a`  in  4  source memory address (COPY, SWAP).
- `req_b`  in  4  target memory address.
- `req_data`  in  4  immediate value (WRITE).
- `opcode`  out  10  to `reg2mem`: [9:8] op, [7:4] field1, [3:0] field2.
- `res`  in  4  from `reg2mem`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  4  response value.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `reg2mem` opcodes:
  - 00 `{data,addr}` stores an immediate.
  - 10 `{reg,addr}` loads mem into a register.
  - 01 `{reg,addr}` stores a register into mem.
  - 11 `{0000,addr}` reads mem onto `res`.
- The idle opcode is `10'b11_0000_0000` (a harmless read of mem[0]).
- Step tables, issued in order:
  - WRITE: `{00,data,b}`.
  - READ: `{11,0000,b}`.
  - COPY: `{10,R0,a}`, `{01,R0,b}`, `{11,0000,b}`.
  - SWAP: `{10,R0,a}`, `{10,R1,b}`, `{01,R0,b}`, `{01,R1,a}`.
- The FSM has three states: IDLE, ISSUE and RESP. The step counter is 3 bits and the hold counter is 4 bits.
- IDLE:
  - `req_ready`=1 and `opcode`=idle.
  - On `req_valid & req_ready`, latch cmd, a, b and data, clear step and hold, and go to ISSUE.
- ISSUE:
  - `opcode` = step-table entry for the current step.
  - Hold increments each cycle.
  - When hold reaches `HOLD_CYCLES-1` on a non-last step: step increments and hold clears.
  - When hold reaches `HOLD_CYCLES-1` on the last step: register `rsp_data` and go to RESP.
- `rsp_data` value per command:
  - READ and COPY: `res` sampled at that edge.
  - WRITE: the latched data.
  - SWAP: 4'd0.
- RESP:
  - `rsp_valid`=1 and `opcode`=idle.
  - `rsp_data` is stable while `rsp_valid` is high.
  - On `rsp_ready`, go to IDLE.
- Requests presented while not in IDLE are ignored (`req_ready`=0). Request inputs are don't-care after acceptance.
- Field widths are fixed: addresses, data and register indices are 4 bits and are used unmodified. No arithmetic is performed.

## Timing
- Reset values: state IDLE, `opcode`=10'b1100000000, `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0, counters 0.
- Reset has priority over every other event. Reset asserted mid-ISSUE or mid-RESP aborts the command: the opcode returns to idle on the next edge and no response is produced. A partially executed SWAP/COPY is not rolled back.
- Accept at edge k: step 0's opcode is visible from k until edge k+HOLD_CYCLES. Each step occupies exactly `HOLD_CYCLES` cycles.
- `rsp_valid` rises at edge k + N·HOLD_CYCLES, where N = 1/1/3/4 steps for WRITE/READ/COPY/SWAP. With the default parameters this is 2/2/6/8 cycles.
- `res` is sampled on the final edge of the last step, i.e. after the read opcode has been held `HOLD_CYCLES` cycles.
- RESP with `rsp_ready` already high lasts exactly one cycle. Back-to-back requests are therefore separated by at least one IDLE cycle (accept requires state IDLE).
- `rsp_ready` held low stalls indefinitely in RESP with `opcode` idle.
- `HOLD_CYCLES`=1 makes the step advance every cycle; the hold-counter wrap must be correct for that case.

## Test plan
- Reset mid-SWAP: issue SWAP a=1, b=2 and assert `rst` at the 3rd ISSUE cycle. Required: next cycle `opcode`=10'b1100000000, `busy`=0, `rsp_valid`=0, `req_ready`=1.
- WRITE then READ: WRITE data=10, b=5, then READ b=5. Required:
  - Opcode sequence 10'b0010100101 then 10'b1100000101.
  - WRITE response `rsp_data`=10.
  - READ response `rsp_data`=10, with `rsp_valid` 2 cycles after accept.
- COPY a=5 → b=11 after mem[5]=10. Required:
  - Opcodes 10'b1011100101, 10'b0111101011, 10'b1100001011, each held 2 cycles.
  - `rsp_data`=10 at 6 cycles after accept.
- SWAP: write mem[1]=3 and mem[2]=9, then SWAP a=1, b=2, then READ 1 and READ 2. Required: reads return 9 and 3, and the SWAP response is 0 after 8 cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after READ completes. Required:
  - `rsp_valid` stays high, `rsp_data` is stable and `opcode` is idle.
  - A `req_valid` pulse during the stall is ignored (`req_ready`=0) and produces no extra opcode.
- Parameter sweep with `HOLD_CYCLES`=1: COPY completes in 3 cycles and each opcode is visible for exactly one cycle.
